// File: rtl/mips_pkg.sv
// Shared definitions for the instruction cache controller.
//   state_e         : controller FSM states
//   BLOCK_W         : width of one cache block in bits (eight 32-bit words)
//   WORDS_PER_BLOCK : instruction words per block
//   OFFSET_W        : byte-offset bits within a block
package mips_pkg;

  localparam int unsigned BLOCK_W         = 256;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned OFFSET_W        = 5;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StMissReq  = 2'd1,
    StMissWait = 2'd2,
    StFill     = 2'd3
  } state_e;

endpackage

// File: rtl/icache_data_array.sv
// Data and tag storage for the direct-mapped instruction cache.
// One synchronous write port, one asynchronous read port. Contents are not reset;
// validity is tracked by the controller.
//   clk_i    : clock
//   we_i     : write enable (block + tag)
//   waddr_i  : write line index
//   wdata_i  : block to write
//   wtag_i   : tag to write
//   raddr_i  : read line index
//   rdata_o  : block at raddr_i
//   rtag_o   : tag at raddr_i
module icache_data_array
  import mips_pkg::*;
#(
  parameter int unsigned NumLines = 16,
  parameter int unsigned TagW     = 23,
  parameter int unsigned IdxW     = $clog2(NumLines)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [IdxW-1:0]     waddr_i,
  input  logic [BLOCK_W-1:0]  wdata_i,
  input  logic [TagW-1:0]     wtag_i,
  input  logic [IdxW-1:0]     raddr_i,
  output logic [BLOCK_W-1:0]  rdata_o,
  output logic [TagW-1:0]     rtag_o
);

  logic [BLOCK_W-1:0] data_q [NumLines];
  logic [TagW-1:0]    tag_q  [NumLines];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_q[waddr_i] <= wdata_i;
      tag_q[waddr_i]  <= wtag_i;
    end
  end

  assign rdata_o = data_q[raddr_i];
  assign rtag_o  = tag_q[raddr_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, blocking instruction cache controller.
// A hit returns the word one cycle after the lookup. A miss freezes the pipeline,
// issues a one-cycle block read, waits for the block, fills the line and returns
// to idle where the held fetch looks up again and hits.
// Optional feature: define ICACHE_STATS_EN to build saturating hit/miss counters;
// otherwise hit_count and miss_count are tied to zero.
//   CLK, RESET        : clock, asynchronous active-low reset
//   Instr_address_2IM : byte fetch address;  fetch_valid : fetch request
//   flush             : invalidate all lines
//   Instr1_fIM        : fetched word;  instr_valid : word is valid
//   FREEZE            : pipeline stall request
//   iBlkRead          : block read request;  iblk_address : block-aligned address
//   block_read_fIM    : returned block;  iblk_ready : block valid this cycle
//   hit_count, miss_count : statistics counters
module icache_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   Instr_address_2IM,
  input  logic                fetch_valid,
  input  logic                flush,
  output logic [31:0]         Instr1_fIM,
  output logic                instr_valid,
  output logic                FREEZE,
  output logic                iBlkRead,
  output logic [ADDR_W-1:0]   iblk_address,
  input  logic [BLOCK_W-1:0]  block_read_fIM,
  input  logic                iblk_ready,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = ADDR_W - OFFSET_W - IdxW;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]    miss_addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [31:0]          instr_q;
  logic                 instr_valid_q;

  logic [IdxW-1:0]      rd_idx, wr_idx;
  logic [TagW-1:0]      rd_tag, arr_tag;
  logic [BLOCK_W-1:0]   arr_data;
  logic [7:0]           word_lsb;
  logic [31:0]          rd_word;
  logic                 hit, lookup, hit_lookup, miss_lookup, fill_we;

  // Lookup always uses the live fetch address; only IDLE acts on the result.
  assign rd_idx   = Instr_address_2IM[OFFSET_W +: IdxW];
  assign rd_tag   = Instr_address_2IM[ADDR_W-1 -: TagW];
  assign word_lsb = {Instr_address_2IM[4:2], 5'b0};
  assign rd_word  = arr_data[word_lsb +: 32];
  assign hit      = valid_q[rd_idx] && (arr_tag == rd_tag);

  // Gated by RESET so FREEZE drops immediately while reset is held.
  assign lookup      = RESET && (state_q == StIdle) && fetch_valid;
  assign hit_lookup  = lookup && hit;
  assign miss_lookup = lookup && !hit;

  // The fill always targets the latched miss address, not the live one.
  assign wr_idx  = miss_addr_q[OFFSET_W +: IdxW];
  assign fill_we = (state_q == StMissWait) && iblk_ready;

  icache_data_array #(
    .NumLines (NUM_LINES),
    .TagW     (TagW),
    .IdxW     (IdxW)
  ) u_data_array (
    .clk_i   (CLK),
    .we_i    (fill_we),
    .waddr_i (wr_idx),
    .wdata_i (block_read_fIM),
    .wtag_i  (miss_addr_q[ADDR_W-1 -: TagW]),
    .raddr_i (rd_idx),
    .rdata_o (arr_data),
    .rtag_o  (arr_tag)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (miss_lookup) state_d = StMissReq;
      StMissReq:  state_d = StMissWait;
      StMissWait: if (iblk_ready) state_d = StFill;
      StFill:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    FREEZE   = (state_q != StIdle) || miss_lookup;
    iBlkRead = (state_q == StMissReq);
  end

  // Datapath: miss address, valid bits, returned word
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      miss_addr_q   <= '0;
      valid_q       <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      if (miss_lookup) miss_addr_q <= Instr_address_2IM;
      // flush wins over a coincident fill so the filled line stays invalid
      if (flush)        valid_q         <= '0;
      else if (fill_we) valid_q[wr_idx] <= 1'b1;
      instr_valid_q <= hit_lookup;
      if (hit_lookup) instr_q <= rd_word;
    end
  end

  assign Instr1_fIM   = instr_q;
  assign instr_valid  = instr_valid_q;
  assign iblk_address = {miss_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  // Byte-in-word and block-offset bits of the latched address are never needed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Instr_address_2IM[1:0], miss_addr_q[OFFSET_W-1:0]};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_lookup && (hit_count_q != '1))   hit_count_q  <= hit_count_q + 32'd1;
      if (miss_lookup && (miss_count_q != '1)) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl (NUM_LINES=16, ADDR_W=32).
module tb_icache_ctrl;

  logic         CLK;
  logic         RESET;
  logic [31:0]  Instr_address_2IM;
  logic         fetch_valid;
  logic         flush;
  logic [31:0]  Instr1_fIM;
  logic         instr_valid;
  logic         FREEZE;
  logic         iBlkRead;
  logic [31:0]  iblk_address;
  logic [255:0] block_read_fIM;
  logic         iblk_ready;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_checks = 0;
  int n_errors = 0;

  icache_ctrl #(
    .NUM_LINES (16),
    .ADDR_W    (32)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Instr_address_2IM (Instr_address_2IM),
    .fetch_valid       (fetch_valid),
    .flush             (flush),
    .Instr1_fIM        (Instr1_fIM),
    .instr_valid       (instr_valid),
    .FREEZE            (FREEZE),
    .iBlkRead          (iBlkRead),
    .iblk_address      (iblk_address),
    .block_read_fIM    (block_read_fIM),
    .iblk_ready        (iblk_ready),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [255:0] make_block(input logic [31:0] base);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = base + k;
    return b;
  endfunction

  // From IDLE: miss on addr, service it with blk, re-lookup hits and returns exp_word.
  task automatic miss_fill(input string tag, input logic [31:0] addr, input logic [255:0] blk,
                           input logic [31:0] exp_word);
    Instr_address_2IM = addr;
    fetch_valid       = 1'b1;
    #1;
    check({tag, ".freeze_at_miss"}, {31'd0, FREEZE}, 32'd1);
    tick();
    check({tag, ".iblkread"}, {31'd0, iBlkRead}, 32'd1);
    check({tag, ".iblk_address"}, iblk_address, {addr[31:5], 5'b0});
    tick();
    check({tag, ".iblkread_one_cycle"}, {31'd0, iBlkRead}, 32'd0);
    block_read_fIM = blk;
    iblk_ready     = 1'b1;
    tick();
    iblk_ready = 1'b0;
    check({tag, ".freeze_in_fill"}, {31'd0, FREEZE}, 32'd1);
    tick();
    check({tag, ".relookup_hits"}, {31'd0, FREEZE}, 32'd0);
    tick();
    check({tag, ".instr_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, ".instr"}, Instr1_fIM, exp_word);
    fetch_valid = 1'b0;
  endtask

  logic [255:0] blk_a, blk_b, blk_c, blk_junk;

  initial begin
    blk_a    = make_block(32'h2402_0009);  // word1 = 0x2402000A
    blk_b    = make_block(32'hB000_0000);
    blk_c    = make_block(32'hC000_0000);
    blk_junk = make_block(32'hDEAD_0000);

    RESET             = 1'b0;
    Instr_address_2IM = 32'h0;
    fetch_valid       = 1'b0;
    flush             = 1'b0;
    block_read_fIM    = '0;
    iblk_ready        = 1'b0;
    #3;
    check("rst.freeze", {31'd0, FREEZE}, 32'd0);
    check("rst.iblkread", {31'd0, iBlkRead}, 32'd0);
    check("rst.iblk_address", iblk_address, 32'd0);
    check("rst.instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst.instr", Instr1_fIM, 32'd0);
    check("rst.hit_count", hit_count, 32'd0);
    check("rst.miss_count", miss_count, 32'd0);
    tick();
    RESET = 1'b1;
    tick();

    // Cold miss, with address wobble and a stray iblk_ready before MISS_WAIT
    Instr_address_2IM = 32'h0040_0004;
    fetch_valid       = 1'b1;
    #1;
    check("cold.freeze_at_once", {31'd0, FREEZE}, 32'd1);
    tick();
    check("cold.iblkread", {31'd0, iBlkRead}, 32'd1);
    check("cold.iblk_address", iblk_address, 32'h0040_0000);
    check("cold.instr_valid_low", {31'd0, instr_valid}, 32'd0);
    Instr_address_2IM = 32'h1234_5678;
    block_read_fIM    = blk_junk;
    iblk_ready        = 1'b1;
    tick();
    iblk_ready = 1'b0;
    check("cold.iblkread_one_cycle", {31'd0, iBlkRead}, 32'd0);
    check("cold.addr_held", iblk_address, 32'h0040_0000);
    check("cold.freeze_wait", {31'd0, FREEZE}, 32'd1);
    tick();
    tick();
    check("cold.still_waiting", {31'd0, FREEZE}, 32'd1);
    block_read_fIM = blk_a;
    iblk_ready     = 1'b1;
    tick();
    iblk_ready        = 1'b0;
    Instr_address_2IM = 32'h0040_0004;
    check("cold.fill_freeze", {31'd0, FREEZE}, 32'd1);
    check("cold.fill_instr_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("cold.relookup_hit", {31'd0, FREEZE}, 32'd0);
    tick();
    check("cold.instr_valid", {31'd0, instr_valid}, 32'd1);
    check("cold.instr", Instr1_fIM, 32'h2402_000A);

    // Hit on word 2, then idle hold, then hit on word 7
    Instr_address_2IM = 32'h0040_0008;
    #1;
    check("hit.no_freeze", {31'd0, FREEZE}, 32'd0);
    tick();
    check("hit.instr_valid", {31'd0, instr_valid}, 32'd1);
    check("hit.instr", Instr1_fIM, 32'h2402_000B);
    fetch_valid = 1'b0;
    tick();
    check("idle.instr_valid", {31'd0, instr_valid}, 32'd0);
    check("idle.instr_held", Instr1_fIM, 32'h2402_000B);
    Instr_address_2IM = 32'h0040_001C;
    fetch_valid       = 1'b1;
    tick();
    fetch_valid = 1'b0;
    check("hit7.instr", Instr1_fIM, 32'h2402_0010);
`ifdef ICACHE_STATS_EN
    check("stats.miss_count", miss_count, 32'd1);
    check("stats.hit_count", hit_count, 32'd3);
`else
    check("stats.miss_count_off", miss_count, 32'd0);
    check("stats.hit_count_off", hit_count, 32'd0);
`endif

    // Conflict: same index 0, different tag evicts
    miss_fill("conflict", 32'h0040_0200, blk_b, 32'hB000_0000);
    miss_fill("refetch", 32'h0040_0000, blk_a, 32'h2402_0009);

    // Flush in the iblk_ready cycle leaves the line invalid
    Instr_address_2IM = 32'h0040_0024;
    fetch_valid       = 1'b1;
    tick();
    tick();
    block_read_fIM = blk_c;
    iblk_ready     = 1'b1;
    flush          = 1'b1;
    tick();
    iblk_ready = 1'b0;
    flush      = 1'b0;
    check("race.fill_freeze", {31'd0, FREEZE}, 32'd1);
    tick();
    miss_fill("race.second", 32'h0040_0024, blk_c, 32'hC000_0001);

    // Flush coincident with a hit still returns the word, then the line is gone
    Instr_address_2IM = 32'h0040_0028;
    fetch_valid       = 1'b1;
    flush             = 1'b1;
    #1;
    check("flushhit.no_freeze", {31'd0, FREEZE}, 32'd0);
    tick();
    flush = 1'b0;
    check("flushhit.instr_valid", {31'd0, instr_valid}, 32'd1);
    check("flushhit.instr", Instr1_fIM, 32'hC000_0002);
    check("flushhit.now_miss", {31'd0, FREEZE}, 32'd1);
    fetch_valid = 1'b0;
    tick();

    // Refill line 1 so reset has a valid line to clear
    miss_fill("prefill", 32'h0040_0020, blk_c, 32'hC000_0000);

    // Reset during MISS_WAIT abandons the miss
    Instr_address_2IM = 32'h0040_0040;
    fetch_valid       = 1'b1;
    tick();
    tick();
    check("rstmiss.in_wait", {31'd0, FREEZE}, 32'd1);
    RESET = 1'b0;
    #1;
    check("rstmiss.freeze", {31'd0, FREEZE}, 32'd0);
    check("rstmiss.iblkread", {31'd0, iBlkRead}, 32'd0);
    check("rstmiss.iblk_address", iblk_address, 32'd0);
    check("rstmiss.instr_valid", {31'd0, instr_valid}, 32'd0);
    fetch_valid = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    block_read_fIM = blk_junk;
    iblk_ready     = 1'b1;
    tick();
    iblk_ready = 1'b0;
    check("rstmiss.ready_ignored", {31'd0, FREEZE}, 32'd0);
    check("rstmiss.counters", hit_count | miss_count, 32'd0);
    fetch_valid       = 1'b1;
    Instr_address_2IM = 32'h0040_0040;
    #1;
    check("rstmiss.line2_invalid", {31'd0, FREEZE}, 32'd1);
    Instr_address_2IM = 32'h0040_0020;
    #1;
    check("rstmiss.line1_invalid", {31'd0, FREEZE}, 32'd1);
    Instr_address_2IM = 32'h0040_0000;
    #1;
    check("rstmiss.line0_invalid", {31'd0, FREEZE}, 32'd1);
    fetch_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
